// File: rtl/alu_share_ctrl_pkg.sv
// alu_ctrl_pkg: shared types and constants for the ALU sharing controller.
//   - ctrl_state_e : sequencer states (IDLE, SETTLE, RESP)
//   - width defaults, flag bit positions within the 4-bit class flag vector
//   - function-code constants used by the ALU and by benches
package alu_ctrl_pkg;

  localparam int ALU_WIDTH_DEF = 16;
  localparam int ALU_FUN_W_DEF = 4;
  localparam int FLAG_W        = 4;

  // Bit positions inside {Arith,Logic,CMP,Shift}
  localparam int FLAG_ARITH = 3;
  localparam int FLAG_LOGIC = 2;
  localparam int FLAG_CMP   = 1;
  localparam int FLAG_SHIFT = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } ctrl_state_e;

  localparam logic [3:0] FUN_ADD     = 4'h0;
  localparam logic [3:0] FUN_SUB     = 4'h1;
  localparam logic [3:0] FUN_AND     = 4'h2;
  localparam logic [3:0] FUN_OR      = 4'h3;
  localparam logic [3:0] FUN_XOR     = 4'h4;
  localparam logic [3:0] FUN_SLT     = 4'h5;
  localparam logic [3:0] FUN_SHL     = 4'h6;
  localparam logic [3:0] FUN_SHR     = 4'h7;
  localparam logic [3:0] FUN_DEFAULT = 4'hF;

endpackage

// File: rtl/alu_share_ctrl_arb.sv
// rr_arb2: two-request round-robin grant, purely combinational.
//   req0, req1   : request valids
//   last_grant   : index of the requester served most recently
//   grant_valid  : at least one request present
//   grant_idx    : selected requester (meaningful only when grant_valid)
// With both requests present the requester that was not served last wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_idx
);

  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = 1'b0;
    if (req0 && req1) begin
      grant_idx = ~last_grant;
    end else if (req1) begin
      grant_idx = 1'b1;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one external combinational ALU between two requesters.
// A round-robin grant picks an operation, its operands/function are registered
// onto the ALU inputs, held for SETTLE_CYCLES, then result and class flags are
// captured and returned over the granted requester's valid/ready response.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   reqN_valid/ready/a/b/fun : request channel of requester N (N = 0,1)
//   rspN_valid/ready         : response handshake of requester N
//   rsp_data, rsp_flags      : captured result and {Arith,Logic,CMP,Shift}
//   alu_a, alu_b, alu_fun    : registered ALU inputs
//   alu_out, alu_flags       : ALU result and flags
//   busy                     : not in IDLE
//   op_count                 : completed operations, wraps at 16 bits
//
// state  | meaning
// IDLE   | waiting for a request; the granted requester sees ready
// SETTLE | ALU inputs held stable while the ALU settles
// RESP   | result held on the granted response channel until taken
import alu_ctrl_pkg::*;

module alu_share_ctrl #(
  parameter int WIDTH         = ALU_WIDTH_DEF,
  parameter int FUN_W         = ALU_FUN_W_DEF,
  parameter int SETTLE_CYCLES = 1              // 1..15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [FUN_W-1:0]  req0_fun,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [FUN_W-1:0]  req1_fun,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  rsp_data,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [FUN_W-1:0]  alu_fun,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic              busy,
  output logic [15:0]       op_count
);

  // Counter starts at SETTLE_CYCLES-1 so capture lands SETTLE_CYCLES edges
  // after the accept edge.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  ctrl_state_e state_q, state_d;
  logic        last_grant_q;
  logic        grant_idx_q;
  logic [3:0]  settle_cnt_q;
  logic        grant_valid;
  logic        grant_idx;
  logic        accept;
  logic        capture;
  logic        rsp_done;

  rr_arb2 u_arb (
    .req0        (req0_valid),
    .req1        (req1_valid),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    capture    = 1'b0;
    rsp_done   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = grant_valid && !grant_idx;
        req1_ready = grant_valid &&  grant_idx;
        if (grant_valid) begin
          accept  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        // Only the granted index has valid high, so only its ready counts.
        rsp_done = grant_idx_q ? rsp1_ready : rsp0_ready;
        if (rsp_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_fun      <= '0;
      rsp_data     <= '0;
      rsp_flags    <= '0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      op_count     <= 16'd0;
      last_grant_q <= 1'b1;
      grant_idx_q  <= 1'b0;
      settle_cnt_q <= 4'd0;
    end else begin
      if (accept) begin
        alu_a        <= grant_idx ? req1_a   : req0_a;
        alu_b        <= grant_idx ? req1_b   : req0_b;
        alu_fun      <= grant_idx ? req1_fun : req0_fun;
        grant_idx_q  <= grant_idx;
        settle_cnt_q <= SETTLE_LOAD;
      end else if (state_q == SETTLE && settle_cnt_q != 4'd0) begin
        settle_cnt_q <= settle_cnt_q - 4'd1;
      end

      if (capture) begin
        rsp_data   <= alu_out;
        rsp_flags  <= alu_flags;
        rsp0_valid <= !grant_idx_q;
        rsp1_valid <=  grant_idx_q;
      end

      if (rsp_done) begin
        rsp0_valid   <= 1'b0;
        rsp1_valid   <= 1'b0;
        last_grant_q <= grant_idx_q;
        op_count     <= op_count + 16'd1;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: table vectors, directed multi-cycle sequences and a
// randomized phase checked against a transaction-level reference model.
// dut0 uses SETTLE_CYCLES=1, dut1 uses SETTLE_CYCLES=4.
import alu_ctrl_pkg::*;

module tb_alu_share_ctrl;

  localparam int S0 = 1;
  localparam int S1 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // dut0 signals
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_fun, req1_fun;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [15:0] rsp_data, alu_a, alu_b, alu_out, op_count;
  logic [3:0]  rsp_flags, alu_fun, alu_flags;
  logic        busy;

  // dut1 signals
  logic        x_req0_valid, x_req0_ready, x_req1_valid, x_req1_ready;
  logic [15:0] x_req0_a, x_req0_b, x_req1_a, x_req1_b;
  logic [3:0]  x_req0_fun, x_req1_fun;
  logic        x_rsp0_valid, x_rsp0_ready, x_rsp1_valid, x_rsp1_ready;
  logic [15:0] x_rsp_data, x_alu_a, x_alu_b, x_alu_out, x_op_count;
  logic [3:0]  x_rsp_flags, x_alu_fun, x_alu_flags;
  logic        x_busy;

  // Bench ALU: returns {flags, result}
  function automatic logic [19:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] f);
    logic [15:0] r;
    logic [3:0]  fl;
    r  = 16'd0;
    fl = 4'd0;
    case (f)
      FUN_ADD: begin r = a + b;                  fl = 4'b1000; end
      FUN_SUB: begin r = a - b;                  fl = 4'b1000; end
      FUN_AND: begin r = a & b;                  fl = 4'b0100; end
      FUN_OR:  begin r = a | b;                  fl = 4'b0100; end
      FUN_XOR: begin r = a ^ b;                  fl = 4'b0100; end
      FUN_SLT: begin r = (a < b) ? 16'd1 : 16'd0; fl = 4'b0010; end
      FUN_SHL: begin r = a << b[3:0];            fl = 4'b0001; end
      FUN_SHR: begin r = a >> b[3:0];            fl = 4'b0001; end
      default: begin r = 16'd0;                  fl = 4'b0000; end
    endcase
    return {fl, r};
  endfunction

  assign {alu_flags, alu_out}     = alu_model(alu_a, alu_b, alu_fun);
  assign {x_alu_flags, x_alu_out} = alu_model(x_alu_a, x_alu_b, x_alu_fun);

  alu_share_ctrl #(.WIDTH(16), .FUN_W(4), .SETTLE_CYCLES(S0)) dut0 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_fun(req0_fun),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_fun(req1_fun),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
    .alu_out(alu_out), .alu_flags(alu_flags), .busy(busy), .op_count(op_count)
  );

  alu_share_ctrl #(.WIDTH(16), .FUN_W(4), .SETTLE_CYCLES(S1)) dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(x_req0_valid), .req0_ready(x_req0_ready), .req0_a(x_req0_a), .req0_b(x_req0_b), .req0_fun(x_req0_fun),
    .req1_valid(x_req1_valid), .req1_ready(x_req1_ready), .req1_a(x_req1_a), .req1_b(x_req1_b), .req1_fun(x_req1_fun),
    .rsp0_valid(x_rsp0_valid), .rsp0_ready(x_rsp0_ready), .rsp1_valid(x_rsp1_valid), .rsp1_ready(x_rsp1_ready),
    .rsp_data(x_rsp_data), .rsp_flags(x_rsp_flags), .alu_a(x_alu_a), .alu_b(x_alu_b), .alu_fun(x_alu_fun),
    .alu_out(x_alu_out), .alu_flags(x_alu_flags), .busy(x_busy), .op_count(x_op_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_a = 0; req0_b = 0; req0_fun = 0; req1_a = 0; req1_b = 0; req1_fun = 0;
    x_req0_valid = 0; x_req1_valid = 0; x_rsp0_ready = 0; x_rsp1_ready = 0;
    x_req0_a = 0; x_req0_b = 0; x_req0_fun = 0; x_req1_a = 0; x_req1_b = 0; x_req1_fun = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic drive_req(input logic idx, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] f);
    if (idx) begin
      req1_valid = 1; req1_a = a; req1_b = b; req1_fun = f;
    end else begin
      req0_valid = 1; req0_a = a; req0_b = b; req0_fun = f;
    end
  endtask

  typedef struct {
    logic        idx;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  fun;
    logic [15:0] exp_data;
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic        grants[8];
    int          n_gr;
    int          both_hi;
    int          stray;
    logic [15:0] held_data;
    // reference model state
    logic        m_pend, m_idx, m_last;
    int          m_acc_cyc;
    logic [15:0] m_count;
    logic [19:0] m_exp;
    logic        v0, v1, e_r0, e_r1, due;

    vecs[0] = '{1'b0, 16'h0003, 16'h0004, FUN_ADD,     16'h0007, 4'b1000};
    vecs[1] = '{1'b1, 16'h000A, 16'h0003, FUN_SUB,     16'h0007, 4'b1000};
    vecs[2] = '{1'b0, 16'h0000, 16'h0001, FUN_SUB,     16'hFFFF, 4'b1000};
    vecs[3] = '{1'b1, 16'hF0F0, 16'h0FF0, FUN_AND,     16'h00F0, 4'b0100};
    vecs[4] = '{1'b0, 16'hF0F0, 16'h0FF0, FUN_OR,      16'hFFF0, 4'b0100};
    vecs[5] = '{1'b1, 16'hFFFF, 16'h0001, FUN_ADD,     16'h0000, 4'b1000};
    vecs[6] = '{1'b0, 16'h0001, 16'h0004, FUN_SHL,     16'h0010, 4'b0001};
    vecs[7] = '{1'b1, 16'h0002, 16'h0005, FUN_SLT,     16'h0001, 4'b0010};
    vecs[8] = '{1'b0, 16'h1234, 16'h5678, FUN_DEFAULT, 16'h0000, 4'b0000};

    // ---------------- reset state
    clear_inputs();
    @(negedge clk);
    do_reset();
    #1;
    check("reset_ctl", {busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready}, 5'b0);
    check("reset_regs", {alu_a, alu_b, alu_fun, rsp_flags}, 40'd0);
    check("reset_data_cnt", {rsp_data, op_count}, 32'd0);

    // ---------------- table vectors, one requester at a time
    for (int i = 0; i < 9; i++) begin
      drive_req(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].fun);
      #1;
      check($sformatf("tbl%0d_ready", i), {req1_ready, req0_ready}, vecs[i].idx ? 2'b10 : 2'b01);
      tick();
      req0_valid = 0; req1_valid = 0;
      #1;
      check($sformatf("tbl%0d_alu", i), {busy, alu_fun, alu_a, alu_b}, {1'b1, vecs[i].fun, vecs[i].a, vecs[i].b});
      tick();
      #1;
      check($sformatf("tbl%0d_rsp", i), {rsp1_valid, rsp0_valid, rsp_flags, rsp_data},
            {vecs[i].idx, !vecs[i].idx, vecs[i].exp_flags, vecs[i].exp_data});
      if (vecs[i].idx) rsp1_ready = 1; else rsp0_ready = 1;
      tick();
      rsp0_ready = 0; rsp1_ready = 0;
      #1;
      check($sformatf("tbl%0d_done", i), {busy, rsp1_valid, rsp0_valid, op_count}, {3'b000, 16'(i + 1)});
    end

    // ---------------- contention: both valid from reset, grants alternate
    do_reset();
    rsp0_ready = 1; rsp1_ready = 1;
    drive_req(1'b0, 16'h0001, 16'h0002, FUN_ADD);
    drive_req(1'b1, 16'h0009, 16'h0004, FUN_SUB);
    n_gr = 0; both_hi = 0;
    for (int c = 0; c < 60 && n_gr < 8; c++) begin
      #1;
      if (req0_ready && req1_ready) both_hi++;
      if (req0_valid && req0_ready) begin grants[n_gr] = 1'b0; n_gr++; end
      else if (req1_valid && req1_ready) begin grants[n_gr] = 1'b1; n_gr++; end
      tick();
    end
    check("cont_n_grants", n_gr, 8);
    check("cont_both_ready", both_hi, 0);
    for (int i = 0; i < n_gr; i++) check($sformatf("cont_grant%0d", i), grants[i], i % 2);
    req0_valid = 0; req1_valid = 0;
    repeat (4) tick();
    #1;
    check("cont_count", op_count, 16'd8);

    // ---------------- backpressure on rsp1; req0 waits, req1 re-asserts
    rsp0_ready = 0; rsp1_ready = 0;
    drive_req(1'b1, 16'h0100, 16'h0023, FUN_ADD);
    #1;
    check("bp_ready1", {req1_ready, req0_ready}, 2'b10);
    tick();
    drive_req(1'b0, 16'h0005, 16'h0006, FUN_ADD);
    rsp0_ready = 1;                           // no rsp0 pending: must be ignored
    tick();
    stray = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (!(rsp1_valid && !rsp0_valid && rsp_data == 16'h0123 && rsp_flags == 4'b1000 &&
            !req0_ready && !req1_ready && busy && op_count == 16'd8)) stray++;
      tick();
    end
    check("bp_hold", stray, 0);
    rsp1_ready = 1;
    req1_valid = 0;
    tick();
    rsp1_ready = 0;
    #1;
    check("bp_release", {rsp1_valid, busy, op_count}, {2'b00, 16'd9});
    check("bp_req0_next", {req1_ready, req0_ready}, 2'b01);
    tick();
    req0_valid = 0;
    tick();
    #1;
    check("bp_req0_rsp", {rsp0_valid, rsp_data}, {1'b1, 16'h000B});
    tick();
    rsp0_ready = 0;
    #1;
    check("bp_req0_done", {rsp0_valid, op_count}, {1'b0, 16'd10});

    // ---------------- reset during SETTLE
    drive_req(1'b0, 16'h0005, 16'h0006, FUN_ADD);
    rsp0_ready = 1;
    tick();
    #1;
    check("rst_mid_settle", busy, 1'b1);
    rst = 1;
    req0_valid = 0;
    tick();
    rst = 0;
    #1;
    check("rst_mid_after", {busy, rsp0_valid, rsp1_valid, op_count}, 19'd0);
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (rsp0_valid || rsp1_valid || busy) stray++;
      tick();
    end
    check("rst_mid_no_stale", stray, 0);
    rsp0_ready = 0;

    // ---------------- settle timing with SETTLE_CYCLES=4 (dut1)
    x_req0_valid = 1; x_req0_a = 16'h1111; x_req0_b = 16'h2222; x_req0_fun = FUN_SUB;
    #1;
    check("s4_ready", x_req0_ready, 1'b1);
    tick();
    x_req0_valid = 0;
    x_req0_a = 16'hDEAD; x_req0_b = 16'hBEEF; x_req0_fun = FUN_AND;
    for (int j = 1; j <= S1; j++) begin
      #1;
      check($sformatf("s4_alu_e%0d", j - 1), {x_alu_fun, x_alu_a, x_alu_b}, {FUN_SUB, 16'h1111, 16'h2222});
      tick();
      #1;
      check($sformatf("s4_valid_e%0d", j), x_rsp0_valid, (j >= S1));
    end
    check("s4_data", {x_rsp_flags, x_rsp_data}, {4'b1000, 16'hEEEF});
    x_rsp0_ready = 1;
    tick();
    x_rsp0_ready = 0;
    #1;
    check("s4_done", {x_rsp0_valid, x_busy}, 2'b00);

    // ---------------- op_count wrap on dut0
    force dut0.op_count = 16'hFFFF;
    #1;
    release dut0.op_count;
    #1;
    check("wrap_pre", op_count, 16'hFFFF);
    drive_req(1'b1, 16'h0001, 16'h0001, FUN_ADD);
    tick();
    req1_valid = 0;
    rsp1_ready = 1;
    tick();
    tick();
    rsp1_ready = 0;
    #1;
    check("wrap_post", op_count, 16'h0000);

    // ---------------- randomized traffic vs. transaction model
    do_reset();
    m_pend = 0; m_idx = 0; m_last = 1; m_acc_cyc = 0; m_count = 0; m_exp = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      v0 = ($urandom_range(0, 2) != 0);
      v1 = ($urandom_range(0, 2) != 0);
      req0_valid = v0; req0_a = 16'($urandom); req0_b = 16'($urandom); req0_fun = 4'($urandom_range(0, 15));
      req1_valid = v1; req1_a = 16'($urandom); req1_b = 16'($urandom); req1_fun = 4'($urandom_range(0, 15));
      rsp0_ready = $urandom_range(0, 1) == 1;
      rsp1_ready = $urandom_range(0, 1) == 1;
      #1;
      e_r0 = 0; e_r1 = 0;
      if (!m_pend) begin
        if (v0 && v1) begin
          if (m_last) e_r0 = 1; else e_r1 = 1;
        end else if (v0) e_r0 = 1;
        else if (v1) e_r1 = 1;
      end
      due = m_pend && (cyc >= m_acc_cyc + 1 + S0);
      check("rand_ctl", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy},
            {e_r0, e_r1, due && !m_idx, due && m_idx, m_pend});
      check("rand_count", op_count, m_count);
      if (due) check("rand_rsp", {rsp_flags, rsp_data}, m_exp);
      if (due && (m_idx ? rsp1_ready : rsp0_ready)) begin
        m_pend = 0; m_last = m_idx; m_count = m_count + 16'd1;
      end else if (e_r0 || e_r1) begin
        m_pend = 1; m_idx = e_r1; m_acc_cyc = cyc;
        m_exp = e_r1 ? alu_model(req1_a, req1_b, req1_fun) : alu_model(req0_a, req0_b, req0_fun);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequencer that shares the single combinational 16-bit ALU between two requesters.
- Round-robin arbitration selects one requester's operation. The operands and function code are registered onto the ALU inputs, held for a fixed settle time, and then the result and the four class flags are captured.
- The captured result is returned to the granted requester over a valid/ready response channel.
- Sits between the ALU and the two client blocks that issue ALU operations; the ALU itself is instantiated outside this block.

Parameters:
- WIDTH, 16, operand and result width.
- FUN_W, 4, function-code width.
- SETTLE_CYCLES, 1, cycles the ALU inputs are held stable before capture; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  controller accepts requester 0 this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_fun  in  FUN_W  requester 0 function code.
- req1_valid, req1_ready, req1_a, req1_b, req1_fun: same as requester 0, for requester 1.
- rsp0_valid  out  1  result available for requester 0.
- rsp0_ready  in  1  requester 0 takes the result.
- rsp1_valid, rsp1_ready: same as requester 0, for requester 1.
- rsp_data  out  WIDTH  captured ALU result (shared by both response channels).
- rsp_flags  out  4  captured {Arith,Logic,CMP,Shift} flags.
- alu_a, alu_b  out  WIDTH  registered ALU operands.
- alu_fun  out  FUN_W  registered ALU function code.
- alu_out  in  WIDTH  ALU result.
- alu_flags  in  4  ALU {Arith,Logic,CMP,Shift} flags.
- busy  out  1  high in any state other than IDLE.
- op_count  out  16  completed-operation counter.

Behaviour:
- Reset (rst=1 at a clk edge) forces:
  - state = IDLE.
  - alu_a, alu_b, alu_fun, rsp_data, rsp_flags = 0.
  - rsp0_valid, rsp1_valid, busy = 0.
  - op_count = 0.
  - last_grant = 1, so requester 0 wins the first contention.
- Reset mid-operation discards the in-flight operation; no response is produced.
- State machine, IDLE -> SETTLE -> RESP -> IDLE:
  - IDLE:
    - Grant selection: if only one req valid, grant it; if both valid, grant the requester != last_grant.
    - reqN_ready = (state==IDLE) && (grant==N); combinational from valid and last_grant.
    - At most one ready high in any cycle.
    - On handshake (valid & ready): latch a/b/fun into alu_a/alu_b/alu_fun, record the granted index, load settle_cnt = SETTLE_CYCLES-1, go to SETTLE.
  - SETTLE:
    - If settle_cnt==0: capture alu_out into rsp_data and alu_flags into rsp_flags, set rspN_valid for the granted index, go to RESP.
    - Otherwise decrement settle_cnt.
    - alu_* stays stable throughout.
  - RESP:
    - rspN_valid, rsp_data and rsp_flags are held until rspN_ready.
    - On the handshake edge: rspN_valid=0, last_grant=N, op_count += 1 (wraps 0xFFFF -> 0x0000), go to IDLE.
- Latency and throughput:
  - Request accepted at edge k; rsp valid from edge k+SETTLE_CYCLES.
  - Minimum spacing between accepts is SETTLE_CYCLES+2 cycles (the IDLE cycle is mandatory).
- Boundaries:
  - req valid may drop before ready without penalty; no grant is recorded.
  - A requester keeping valid high during its own RESP is not accepted until the next IDLE.
  - Both valid continuously: grants strictly alternate 0,1,0,1...
  - rspN_ready asserted while rspN_valid=0 is ignored.
  - The response for requester N never asserts rsp of the other index.
  - All 16 fun codes, including 4'b1111 (ALU default), are forwarded unchanged; the controller does not decode them.
  - alu_* retain the last operation's values while IDLE; they do not return to zero.

Decomposition:
- Package alu_ctrl_pkg:
  - state enum {IDLE, SETTLE, RESP}.
  - WIDTH/FUN_W defaults.
  - flag bit indices ARITH=3, LOGIC=2, CMP=1, SHIFT=0.
  - FUN code constants used by benches.
- Sub-module rr_arb2: two-request round-robin grant from valid and last_grant; purely combinational; instantiated once.
- Everything else (FSM, registers, counter) lives in alu_share_ctrl.

Test Plan:
The bench connects the team's 16-bit ALU, with fun 4'b0000 = add and 4'b0001 = subtract.
- Single op: after reset, req0 = (a=0x0003, b=0x0004, fun=0000) -> req0_ready the same cycle; rsp0_valid 1 cycle later (SETTLE_CYCLES=1); rsp_data=0x0007, Arith flag=1; op_count=1.
- Contention: req0 and req1 both valid from reset -> req0 granted first; after rsp0 handshake, req1 granted; with both held, grants alternate 0,1,0,1 over 8 ops.
- Backpressure: rsp1_ready held 0 for 10 cycles -> rsp1_valid and rsp_data stable; req0_ready stays 0; busy=1 throughout.
- Settle timing: SETTLE_CYCLES=4 -> alu_a/alu_b/alu_fun stable for 4 cycles; capture occurs on the 4th edge after accept.
- Reset mid-op: rst asserted during SETTLE -> next cycle state IDLE, rsp valids 0, op_count=0; no stale response afterwards.
- Wrap: preload op_count to 0xFFFF by running 65535 ops (or force) -> next completed op gives 0x0000.
